// File: rtl/power_fn_pipe.sv
// power_fn_pipe -- two-stage valid/ready pipeline computing, bitwise on every
// channel, y = (a & c) | (b & (a ^ (c & d))), with per-channel output toggle
// statistics.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for operand set n_1..n_4 (a, b, c, d)
//   n_1..n_4            NCH*W operands, channel k at [k*W +: W]
//   out_valid/out_ready output handshake for out_y
//   out_y               NCH*W result, channel-packed like the operands
//   tog_clr             synchronous clear of toggle statistics
//   tog_cnt             NCH*CNT_W per-channel saturating output toggle counts
//   tog_sat             NCH sticky per-channel saturation flags
module power_fn_pipe #(
  parameter int unsigned W     = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*W-1:0]     n_1,
  input  logic [NCH*W-1:0]     n_2,
  input  logic [NCH*W-1:0]     n_3,
  input  logic [NCH*W-1:0]     n_4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*W-1:0]     out_y,
  input  logic                 tog_clr,
  output logic [NCH*CNT_W-1:0] tog_cnt,
  output logic [NCH-1:0]       tog_sat
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic             s1_full;
  logic             s2_full;
  logic             s1_moves;
  logic             in_xfer;
  logic             out_xfer;
  logic [NCH*W-1:0] p_q;
  logic [NCH*W-1:0] q_q;
  logic [NCH*W-1:0] r_q;
  logic [NCH*W-1:0] y_q;

  logic [W-1:0]     last_y [NCH];
  logic [CNT_W-1:0] cnt_q  [NCH];
  logic [CNT_W:0]   sum    [NCH];

  function automatic logic [CNT_W:0] popcount(input logic [W-1:0] v);
    logic [CNT_W:0] c;
    c = '0;
    for (int unsigned i = 0; i < W; i++) begin
      c = c + {{CNT_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // S1 drains whenever S2 is empty or S2's result leaves this cycle.
  assign s1_moves  = s1_full & (~s2_full | out_ready);
  // Gated by rst_n so the block refuses input while held in reset.
  assign in_ready  = rst_n & (~s1_full | s1_moves);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = s2_full & out_ready;
  assign out_valid = s2_full;
  assign out_y     = y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_full <= 1'b0;
      s2_full <= 1'b0;
      p_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      y_q     <= '0;
    end else begin
      if (in_xfer)
        s1_full <= 1'b1;
      else if (s1_moves)
        s1_full <= 1'b0;

      if (s1_moves)
        s2_full <= 1'b1;
      else if (out_xfer)
        s2_full <= 1'b0;

      // Data registers only load on an accepted transfer (operand isolation).
      if (in_xfer) begin
        p_q <= n_1 & n_3;
        q_q <= n_2;
        r_q <= n_1 ^ (n_3 & n_4);
      end
      if (s1_moves)
        y_q <= p_q | (q_q & r_q);
    end
  end

  always_comb begin
    sum = '{default: '0};
    for (int unsigned k = 0; k < NCH; k++) begin
      sum[k] = {1'b0, cnt_q[k]} + popcount(y_q[k*W +: W] ^ last_y[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        last_y[k]  <= '0;
        cnt_q[k]   <= '0;
        tog_sat[k] <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (out_xfer)
          last_y[k] <= y_q[k*W +: W];
        // Clear outranks a coincident count update; last_y still follows.
        if (tog_clr) begin
          cnt_q[k]   <= '0;
          tog_sat[k] <= 1'b0;
        end else if (out_xfer) begin
          if (sum[k] > CNT_MAX) begin
            cnt_q[k]   <= '1;
            tog_sat[k] <= 1'b1;
          end else begin
            cnt_q[k] <= sum[k][CNT_W-1:0];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign tog_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_power_fn_pipe.sv
// Directed testbench for power_fn_pipe: a default instance (W=8, NCH=4,
// CNT_W=16) and a CNT_W=4 instance sharing the same stimulus for saturation.
module tb_power_fn_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] n_1, n_2, n_3, n_4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        tog_clr;
  logic [63:0] tog_cnt;
  logic [3:0]  tog_sat;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_y4;
  logic [15:0] tog_cnt4;
  logic [3:0]  tog_sat4;

  int n_checks;
  int n_fail;

  power_fn_pipe #(.W(8), .NCH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .n_1(n_1), .n_2(n_2), .n_3(n_3), .n_4(n_4),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .tog_clr(tog_clr), .tog_cnt(tog_cnt), .tog_sat(tog_sat)
  );

  power_fn_pipe #(.W(8), .NCH(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .n_1(n_1), .n_2(n_2), .n_3(n_3), .n_4(n_4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_y(out_y4),
    .tog_clr(tog_clr), .tog_cnt(tog_cnt4), .tog_sat(tog_sat4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; tog_clr = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
    n_1 = a; n_2 = b; n_3 = c; n_4 = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 8 && out_valid !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tog_clr = 1'b0;
    n_1 = '0; n_2 = '0; n_3 = '0; n_4 = '0;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_y !== 32'h0) begin n_fail++; $display("FAIL rst_out_y got %h want 0", out_y); end
    n_checks++; if (tog_cnt !== 64'h0) begin n_fail++; $display("FAIL rst_tog_cnt got %h want 0", tog_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_out_valid got %b want 0", out_valid); end
    n_checks++; if (tog_cnt !== 64'h0) begin n_fail++; $display("FAIL rel_tog_cnt got %h want 0", tog_cnt); end
    n_checks++; if (tog_sat !== 4'h0) begin n_fail++; $display("FAIL rel_tog_sat got %h want 0", tog_sat); end
    n_checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin n_fail++; $display("FAIL rel_dut4 got rdy=%b vld=%b want 1/0", in_ready4, out_valid4); end
  endtask

  task automatic test_single();
    do_reset();
    send(32'hAA, 32'hFF, 32'hCC, 32'hF0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %b want 0", out_valid); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got %b want 1", out_valid); end
    n_checks++; if (out_y !== 32'h0000_00EA) begin n_fail++; $display("FAIL single_y got %h want 000000ea", out_y); end
    @(negedge clk);
    n_checks++; if (tog_cnt !== 64'd5) begin n_fail++; $display("FAIL single_tog got %h want 5", tog_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_toggle_seq();
    do_reset();
    send(32'hFF, 32'h00, 32'h0F, 32'h00);
    wait_out();
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h0F) begin n_fail++; $display("FAIL seq_y0 got vld=%b y=%h want 1/0000000f", out_valid, out_y); end
    @(negedge clk);
    n_checks++; if (tog_cnt !== 64'd4) begin n_fail++; $display("FAIL seq_tog0 got %h want 4", tog_cnt); end
    send(32'h00, 32'h00, 32'h0F, 32'h00);
    wait_out();
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h00) begin n_fail++; $display("FAIL seq_y1 got vld=%b y=%h want 1/00000000", out_valid, out_y); end
    @(negedge clk);
    n_checks++; if (tog_cnt !== 64'd8) begin n_fail++; $display("FAIL seq_tog1 got %h want 8", tog_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    n_1 = 32'hFF; n_2 = 32'h00; n_3 = 32'h0F; n_4 = 32'h00; in_valid = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc0 got %b want 1", in_ready); end
    @(negedge clk);
    n_1 = 32'hAA; n_2 = 32'hFF; n_3 = 32'hCC; n_4 = 32'hF0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_acc1 got %b want 1", in_ready); end
    @(negedge clk);
    n_1 = 32'hF0; n_2 = 32'h00; n_3 = 32'hFF; n_4 = 32'h00;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h0F) begin n_fail++; $display("FAIL bp_head got vld=%b y=%h want 1/0000000f", out_valid, out_y); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0 || out_y !== 32'h0F) begin n_fail++; $display("FAIL bp_hold got rdy=%b y=%h want 0/0000000f", in_ready, out_y); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'hEA) begin n_fail++; $display("FAIL bp_y1 got vld=%b y=%h want 1/000000ea", out_valid, out_y); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'hF0) begin n_fail++; $display("FAIL bp_y2 got vld=%b y=%h want 1/000000f0", out_valid, out_y); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_nodup got %b want 0", out_valid); end
    n_checks++; if (tog_cnt !== 64'd12) begin n_fail++; $display("FAIL bp_tog got %h want 12", tog_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] vc [4];
    logic [31:0] vd [4];
    logic [31:0] vy [4];
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0000; vc[0] = 32'h0F0F_0F0F; vd[0] = 32'h0000_0000; vy[0] = 32'h0F0F_0F0F;
    va[1] = 32'hAAAA_AAAA; vb[1] = 32'hFFFF_FFFF; vc[1] = 32'hCCCC_CCCC; vd[1] = 32'hF0F0_F0F0; vy[1] = 32'hEAEA_EAEA;
    va[2] = 32'h0000_00FF; vb[2] = 32'hFF00_FF00; vc[2] = 32'h0000_FFFF; vd[2] = 32'h00FF_FFFF; vy[2] = 32'h0000_FFFF;
    va[3] = 32'hF0F0_F0F0; vb[3] = 32'h0F0F_0F0F; vc[3] = 32'h3C3C_3C3C; vd[3] = 32'hFF00_FF00; vy[3] = 32'h3C30_3C30;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        n_1 = va[k]; n_2 = vb[k]; n_3 = vc[k]; n_4 = vd[k]; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want 1", k, in_ready); end
      end else begin
        in_valid = 1'b0;
      end
      if (k >= 2) begin
        n_checks++; if (out_valid !== 1'b1 || out_y !== vy[k-2]) begin n_fail++; $display("FAIL b2b_y[%0d] got vld=%b y=%h want 1/%h", k-2, out_valid, out_y, vy[k-2]); end
      end
      @(negedge clk);
    end
    n_1 = 32'h1234_5678; n_2 = 32'h9ABC_DEF0; n_3 = 32'hFFFF_FFFF; n_4 = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || out_y !== 32'h3C30_3C30) begin n_fail++; $display("FAIL b2b_idle got vld=%b y=%h want 0/3c303c30", out_valid, out_y); end
  endtask

  task automatic test_saturation();
    do_reset();
    send(32'hFF, 32'hFF, 32'hFF, 32'h00);
    wait_out();
    @(negedge clk);
    n_checks++; if (tog_cnt4 !== 16'h0008 || tog_sat4 !== 4'h0) begin n_fail++; $display("FAIL sat_first got cnt=%h sat=%h want 0008/0", tog_cnt4, tog_sat4); end
    send(32'h00, 32'h00, 32'h00, 32'h00);
    wait_out();
    @(negedge clk);
    n_checks++; if (tog_cnt4 !== 16'h000F || tog_sat4 !== 4'h1) begin n_fail++; $display("FAIL sat_hit got cnt=%h sat=%h want 000f/1", tog_cnt4, tog_sat4); end
    send(32'hFF, 32'hFF, 32'hFF, 32'h00);
    wait_out();
    @(negedge clk);
    n_checks++; if (tog_cnt4 !== 16'h000F || tog_sat4 !== 4'h1) begin n_fail++; $display("FAIL sat_hold got cnt=%h sat=%h want 000f/1", tog_cnt4, tog_sat4); end
    n_checks++; if (tog_cnt !== 64'd24) begin n_fail++; $display("FAIL sat_wide got %h want 24", tog_cnt); end
    tog_clr = 1'b1;
    @(negedge clk);
    tog_clr = 1'b0;
    n_checks++; if (tog_cnt4 !== 16'h0000 || tog_sat4 !== 4'h0) begin n_fail++; $display("FAIL sat_clr got cnt=%h sat=%h want 0000/0", tog_cnt4, tog_sat4); end
  endtask

  task automatic test_clear_coincident();
    do_reset();
    send(32'hFF, 32'h00, 32'h0F, 32'h00);
    wait_out();
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h0F) begin n_fail++; $display("FAIL clr_y got vld=%b y=%h want 1/0000000f", out_valid, out_y); end
    tog_clr = 1'b1;
    @(negedge clk);
    tog_clr = 1'b0;
    n_checks++; if (tog_cnt !== 64'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_cnt got cnt=%h vld=%b want 0/0", tog_cnt, out_valid); end
    send(32'h00, 32'h00, 32'h0F, 32'h00);
    wait_out();
    n_checks++; if (out_valid !== 1'b1 || out_y !== 32'h00) begin n_fail++; $display("FAIL clr_y2 got vld=%b y=%h want 1/00000000", out_valid, out_y); end
    @(negedge clk);
    n_checks++; if (tog_cnt !== 64'd4 || tog_sat !== 4'h0) begin n_fail++; $display("FAIL clr_next got cnt=%h sat=%h want 4/0", tog_cnt, tog_sat); end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    out_ready = 1'b0;
    n_1 = 32'hFF; n_2 = 32'h00; n_3 = 32'h0F; n_4 = 32'h00; in_valid = 1'b1;
    @(negedge clk);
    n_1 = 32'hAA; n_2 = 32'hFF; n_3 = 32'hCC; n_4 = 32'hF0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rif_loaded got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_y !== 32'h0) begin n_fail++; $display("FAIL rif_async got vld=%b rdy=%b y=%h want 0/0/0", out_valid, in_ready, out_y); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rif_ready got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_ghost[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_toggle_seq();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_clear_coincident();
    test_reset_in_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
